// File: rtl/sram_controller.sv
// sram_controller: turns single-cycle CPU memory requests into sequenced
// async SRAM CE/OE/WE cycles with wait states, byte lanes and a tri-state bus.
module sram_controller #(
    parameter int unsigned WaitStates = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_i,
    input  logic        Write_i,
    input  logic [15:0] Addr_i,
    input  logic [15:0] WData_i,
    input  logic [1:0]  ByteEn_i,
    output logic [15:0] RData_o,
    output logic        Ready_o,
    output logic        Busy_o,
    output logic        CE_o,
    output logic        OE_o,
    output logic        WE_o,
    output logic        LB_o,
    output logic        UB_o,
    output logic [19:0] ADDR_o,
    inout  logic [15:0] DQ_io
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
    localparam logic [3:0] CNT_INIT = WaitStates[3:0];
    state_t      state_q;
    logic        write_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;
    logic [3:0]  cnt_q;
    logic [15:0] rdata_q;
    logic        ready_q;
    logic        busy_q;
    logic        ce_q;
    logic        oe_q;
    logic        we_q;
    logic        lb_q;
    logic        ub_q;
    logic        dq_oe_q;
    assign RData_o = rdata_q;
    assign Ready_o = ready_q;
    assign Busy_o  = busy_q;
    assign CE_o    = ce_q;
    assign OE_o    = oe_q;
    assign WE_o    = we_q;
    assign LB_o    = lb_q;
    assign UB_o    = ub_q;
    assign ADDR_o  = {4'b0, addr_q};
    assign DQ_io   = dq_oe_q ? wdata_q : 16'hzzzz;
    // Every strobe is set on the edge entering the state it belongs to, so pins never see Req combinationally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            lb_q    <= 1'b1;
            ub_q    <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (Req_i) begin
                    write_q <= Write_i;
                    addr_q  <= Addr_i;
                    wdata_q <= WData_i;
                    be_q    <= ByteEn_i;
                    cnt_q   <= CNT_INIT;
                    busy_q  <= 1'b1;
                    ce_q    <= 1'b0;
                    lb_q    <= ~ByteEn_i[0];
                    ub_q    <= ~ByteEn_i[1];
                    dq_oe_q <= Write_i;
                    state_q <= SETUP;
                end
                SETUP: begin
                    oe_q    <= write_q;
                    we_q    <= ~write_q;
                    state_q <= STROBE;
                end
                STROBE: if (cnt_q == 4'd0) begin
                    oe_q <= 1'b1;
                    we_q <= 1'b1;
                    if (write_q) begin
                        state_q <= HOLD;
                    end else begin
                        rdata_q <= DQ_io & {{8{be_q[1]}}, {8{be_q[0]}}};
                        ce_q    <= 1'b1;
                        lb_q    <= 1'b1;
                        ub_q    <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                HOLD: begin
                    ce_q    <= 1'b1;
                    lb_q    <= 1'b1;
                    ub_q    <= 1'b1;
                    dq_oe_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of sram_controller against a behavioural async SRAM,
// with instances at WaitStates 0, 1 (default) and 3.
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req [3];
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  be = '0;
    logic [15:0] rdata_w [3];
    logic        ready_w [3];
    logic        busy_w [3];
    logic        ce_w [3];
    logic        oe_w [3];
    logic        we_w [3];
    logic        lb_w [3];
    logic        ub_w [3];
    logic [19:0] adr_w [3];
    wire  [15:0] dq0;
    wire  [15:0] dq1;
    wire  [15:0] dq3;
    logic [15:0] mem [64];
    int n_cmp = 0;
    int n_bad = 0;
    int lat, oe_lo, we_lo, both_lo, dq_bad, lane_bad;
    logic [15:0] rd;

    always #5 clk = ~clk;

    sram_controller #(.WaitStates(0)) u_w0 (
        .Clk(clk), .Reset(rst), .Req_i(req[0]), .Write_i(wr), .Addr_i(addr), .WData_i(wdata),
        .ByteEn_i(be), .RData_o(rdata_w[0]), .Ready_o(ready_w[0]), .Busy_o(busy_w[0]), .CE_o(ce_w[0]),
        .OE_o(oe_w[0]), .WE_o(we_w[0]), .LB_o(lb_w[0]), .UB_o(ub_w[0]), .ADDR_o(adr_w[0]), .DQ_io(dq0));
    sram_controller u_dut (
        .Clk(clk), .Reset(rst), .Req_i(req[1]), .Write_i(wr), .Addr_i(addr), .WData_i(wdata),
        .ByteEn_i(be), .RData_o(rdata_w[1]), .Ready_o(ready_w[1]), .Busy_o(busy_w[1]), .CE_o(ce_w[1]),
        .OE_o(oe_w[1]), .WE_o(we_w[1]), .LB_o(lb_w[1]), .UB_o(ub_w[1]), .ADDR_o(adr_w[1]), .DQ_io(dq1));
    sram_controller #(.WaitStates(3)) u_w3 (
        .Clk(clk), .Reset(rst), .Req_i(req[2]), .Write_i(wr), .Addr_i(addr), .WData_i(wdata),
        .ByteEn_i(be), .RData_o(rdata_w[2]), .Ready_o(ready_w[2]), .Busy_o(busy_w[2]), .CE_o(ce_w[2]),
        .OE_o(oe_w[2]), .WE_o(we_w[2]), .LB_o(lb_w[2]), .UB_o(ub_w[2]), .ADDR_o(adr_w[2]), .DQ_io(dq3));

    // SRAM model: drives the whole word while CE and OE are low; writes only through the default instance.
    assign dq0 = (!ce_w[0] && !oe_w[0]) ? mem[adr_w[0][5:0]] : 16'hzzzz;
    assign dq1 = (!ce_w[1] && !oe_w[1]) ? mem[adr_w[1][5:0]] : 16'hzzzz;
    assign dq3 = (!ce_w[2] && !oe_w[2]) ? mem[adr_w[2][5:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
            mem[1] <= 16'hAE01;
            mem[3] <= 16'hFE00;
            mem[5] <= 16'h16CA;
            mem[6] <= 16'h1B70;
        end else if (!ce_w[1] && !we_w[1]) begin
            if (!lb_w[1]) mem[adr_w[1][5:0]][7:0] <= dq1[7:0];
            if (!ub_w[1]) mem[adr_w[1][5:0]][15:8] <= dq1[15:8];
        end
    end

    function automatic logic [15:0] dqsel(input int s);
        return (s == 0) ? dq0 : (s == 1) ? dq1 : dq3;
    endfunction

    // An undriven bus reads as Z on 4-state simulators and as 0 on 2-state ones.
    function automatic bit undrv(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    task automatic xact(input int s, input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
        @(negedge clk);
        wr = w; addr = a; wdata = d; be = b; req[s] = 1'b1;
        @(posedge clk);
        #1 req[s] = 1'b0;
        lat = 0; oe_lo = 0; we_lo = 0; both_lo = 0; dq_bad = 0; lane_bad = 0; rd = 16'hxxxx;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (!oe_w[s]) oe_lo++;
            if (!we_w[s]) we_lo++;
            if (!oe_w[s] && !we_w[s]) both_lo++;
            if (w) begin
                if (!ce_w[s] && dqsel(s) !== d) dq_bad++;
                if (ce_w[s] && !undrv(dqsel(s))) dq_bad++;
            end else if (oe_w[s] && !undrv(dqsel(s))) dq_bad++;
            if (!ce_w[s] && (lb_w[s] !== ~b[0] || ub_w[s] !== ~b[1])) lane_bad++;
            if (ready_w[s]) begin lat = k; rd = rdata_w[s]; end
        end
    endtask

    task automatic test_reset;
        n_cmp++; if ({ce_w[1], oe_w[1], we_w[1], lb_w[1], ub_w[1]} !== 5'b11111) begin n_bad++; $display("FAIL rst_strobes: got %b want 11111", {ce_w[1], oe_w[1], we_w[1], lb_w[1], ub_w[1]}); end
        n_cmp++; if (adr_w[1] !== 20'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 00000", adr_w[1]); end
        n_cmp++; if (rdata_w[1] !== 16'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0000", rdata_w[1]); end
        n_cmp++; if (ready_w[1] !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", ready_w[1]); end
        n_cmp++; if (busy_w[1] !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_w[1]); end
        n_cmp++; if (!undrv(dq1)) begin n_bad++; $display("FAIL rst_dq: got %h want undriven", dq1); end
    endtask

    task automatic test_default_read;
        xact(1, 1'b0, 16'd1, 16'hDEAD, 2'b11);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rd_latency: got %0d want 4", lat); end
        n_cmp++; if (rd !== 16'hAE01) begin n_bad++; $display("FAIL rd_data: got %h want AE01", rd); end
        n_cmp++; if (oe_lo !== 2) begin n_bad++; $display("FAIL rd_oe_cycles: got %0d want 2", oe_lo); end
        n_cmp++; if (we_lo !== 0) begin n_bad++; $display("FAIL rd_we_cycles: got %0d want 0", we_lo); end
        n_cmp++; if (dq_bad !== 0) begin n_bad++; $display("FAIL rd_dq_driven: got %0d cycles want 0", dq_bad); end
    endtask

    task automatic test_write_readback;
        xact(1, 1'b1, 16'd12, 16'h1234, 2'b11);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL wr_latency: got %0d want 5", lat); end
        n_cmp++; if (we_lo !== 2) begin n_bad++; $display("FAIL wr_we_cycles: got %0d want 2", we_lo); end
        n_cmp++; if (oe_lo !== 0) begin n_bad++; $display("FAIL wr_oe_cycles: got %0d want 0", oe_lo); end
        n_cmp++; if (both_lo !== 0) begin n_bad++; $display("FAIL wr_oe_we_overlap: got %0d want 0", both_lo); end
        n_cmp++; if (dq_bad !== 0) begin n_bad++; $display("FAIL wr_dq_drive: got %0d bad cycles want 0", dq_bad); end
        xact(1, 1'b0, 16'd12, 16'hDEAD, 2'b11);
        n_cmp++; if (rd !== 16'h1234) begin n_bad++; $display("FAIL wr_readback: got %h want 1234", rd); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL wr_readback_latency: got %0d want 4", lat); end
    endtask

    task automatic test_byte_lane;
        xact(1, 1'b1, 16'd3, 16'hAB55, 2'b01);
        n_cmp++; if (lane_bad !== 0) begin n_bad++; $display("FAIL bl_lanes: got %0d bad cycles want 0", lane_bad); end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL bl_latency: got %0d want 5", lat); end
        xact(1, 1'b0, 16'd3, 16'hDEAD, 2'b11);
        n_cmp++; if (rd !== 16'hFE55) begin n_bad++; $display("FAIL bl_readback: got %h want FE55", rd); end
        xact(1, 1'b0, 16'd3, 16'hDEAD, 2'b10);
        n_cmp++; if (rd !== 16'hFE00) begin n_bad++; $display("FAIL bl_upper_only: got %h want FE00", rd); end
        xact(1, 1'b0, 16'd1, 16'hDEAD, 2'b00);
        n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL bl_none_data: got %h want 0000", rd); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL bl_none_latency: got %0d want 4", lat); end
        n_cmp++; if (lane_bad !== 0) begin n_bad++; $display("FAIL bl_none_lanes: got %0d bad cycles want 0", lane_bad); end
    endtask

    task automatic test_wait_states;
        xact(0, 1'b0, 16'd1, 16'hDEAD, 2'b11);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL ws0_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== 16'hAE01) begin n_bad++; $display("FAIL ws0_data: got %h want AE01", rd); end
        n_cmp++; if (oe_lo !== 1) begin n_bad++; $display("FAIL ws0_oe_cycles: got %0d want 1", oe_lo); end
        xact(2, 1'b0, 16'd1, 16'hDEAD, 2'b11);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL ws3_latency: got %0d want 6", lat); end
        n_cmp++; if (rd !== 16'hAE01) begin n_bad++; $display("FAIL ws3_data: got %h want AE01", rd); end
        n_cmp++; if (oe_lo !== 4) begin n_bad++; $display("FAIL ws3_oe_cycles: got %0d want 4", oe_lo); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] seq [4];
        logic [15:0] exp_d [4];
        int idx = 0;
        int idle = 0;
        logic pb = 1'b0;
        seq = '{16'd5, 16'd6, 16'd5, 16'd6};
        exp_d = '{16'h16CA, 16'h1B70, 16'h16CA, 16'h1B70};
        @(negedge clk);
        wr = 1'b0; be = 2'b11; wdata = 16'hDEAD; addr = seq[0]; req[1] = 1'b1;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            @(negedge clk);
            if (busy_w[1] && !pb) begin
                if (idx > 0) begin
                    n_cmp++; if (idle !== 1) begin n_bad++; $display("FAIL b2b_idle_gap: got %0d idle cycles want 1", idle); end
                end
                idle = 0;
            end
            if (!busy_w[1]) idle++;
            if (busy_w[1]) begin
                n_cmp++; if (adr_w[1] !== {4'h0, seq[idx]}) begin n_bad++; $display("FAIL b2b_addr: got %h want %h", adr_w[1], {4'h0, seq[idx]}); end
            end
            if (ready_w[1]) begin
                n_cmp++; if (rdata_w[1] !== exp_d[idx]) begin n_bad++; $display("FAIL b2b_data: got %h want %h", rdata_w[1], exp_d[idx]); end
                idx++;
                if (idx < 4) addr = seq[idx]; else req[1] = 1'b0;
            end else if (busy_w[1]) addr = 16'h0007;
            pb = busy_w[1];
        end
        req[1] = 1'b0;
        n_cmp++; if (idx !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d transactions want 4", idx); end
    endtask

    task automatic test_reset_mid_op;
        int rdy = 0;
        @(negedge clk);
        wr = 1'b1; addr = 16'd20; wdata = 16'h5A5A; be = 2'b11; req[1] = 1'b1;
        @(posedge clk);
        #1 req[1] = 1'b0;
        for (int k = 0; k < 10 && we_w[1] !== 1'b0; k++) @(negedge clk);
        n_cmp++; if (we_w[1] !== 1'b0) begin n_bad++; $display("FAIL rmo_strobe_reached: got WE=%b want 0", we_w[1]); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({ce_w[1], oe_w[1], we_w[1], lb_w[1], ub_w[1]} !== 5'b11111) begin n_bad++; $display("FAIL rmo_strobes: got %b want 11111", {ce_w[1], oe_w[1], we_w[1], lb_w[1], ub_w[1]}); end
        n_cmp++; if (!undrv(dq1)) begin n_bad++; $display("FAIL rmo_dq: got %h want undriven", dq1); end
        n_cmp++; if (ready_w[1] !== 1'b0) begin n_bad++; $display("FAIL rmo_ready: got %b want 0", ready_w[1]); end
        n_cmp++; if (busy_w[1] !== 1'b0) begin n_bad++; $display("FAIL rmo_busy: got %b want 0", busy_w[1]); end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ready_w[1]) rdy++;
        end
        n_cmp++; if (rdy !== 0) begin n_bad++; $display("FAIL rmo_no_ready: got %0d pulses want 0", rdy); end
    endtask

    initial begin
        req[0] = 1'b0; req[1] = 1'b0; req[2] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_default_read;
        test_write_readback;
        test_byte_lane;
        test_wait_states;
        test_back_to_back;
        test_reset_mid_op;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
